// File: rtl/button_bit_sampler_if.sv
// Signal bundle between the push-button front end and its consumer.
// master: drives raw button/sw0, reads the strobe outputs.
// slave:  the sampler itself.
// Signals:
//   button      raw bouncy push-button, active-high
//   sw0         raw slide switch, the data bit
//   bit_valid   one-cycle strobe per accepted press
//   bit_data    sw0 value captured with the strobe
//   btn_level   debounced button level
//   press_count wrapping count of strobes
interface button_bit_sampler_if;

    logic       button;
    logic       sw0;
    logic       bit_valid;
    logic       bit_data;
    logic       btn_level;
    logic [7:0] press_count;

    modport master (
        output button,
        output sw0,
        input  bit_valid,
        input  bit_data,
        input  btn_level,
        input  press_count
    );

    modport slave (
        input  button,
        input  sw0,
        output bit_valid,
        output bit_data,
        output btn_level,
        output press_count
    );

endinterface

// File: rtl/button_bit_sampler.sv
// Debounced push-button sampler: turns a raw button plus slide switch into
// a single-cycle bit strobe with the switch value captured at that moment.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    slave side of button_bit_sampler_if
//          (button, sw0 in; bit_valid, bit_data, btn_level, press_count out)
// Optional: define BTN_REPEAT_EN to emit auto-repeat strobes every
// REPEAT_CYCLES cycles while the button stays held.
module button_bit_sampler #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REPEAT_CYCLES   = 50000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    button_bit_sampler_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two-flop synchronizers; bit 1 is the stable sample.
    logic [1:0] sync_btn_q;
    logic [1:0] sync_sw_q;
    logic       btn_s;
    logic       sw_s;

    state_e     state_q;
    state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       bit_valid_q;
    logic       bit_valid_d;
    logic       bit_data_q;
    logic       bit_data_d;
    logic       btn_level_q;
    logic       btn_level_d;
    logic [7:0] press_count_q;
    logic [7:0] press_count_d;

    logic       accept;
    logic       rep_fire;
    logic       strobe;

    assign btn_s = sync_btn_q[1];
    assign sw_s  = sync_sw_q[1];

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_btn_q <= 2'b00;
            sync_sw_q  <= 2'b00;
        end else begin
            sync_btn_q <= {sync_btn_q[0], bus.button};
            sync_sw_q  <= {sync_sw_q[0], bus.sw0};
        end
    end

    // ------------------------------------------------------------------
    // State register (with the registered outputs that move with it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_valid_q   <= 1'b0;
            bit_data_q    <= 1'b0;
            btn_level_q   <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_valid_q   <= bit_valid_d;
            bit_data_q    <= bit_data_d;
            btn_level_q   <= btn_level_d;
            press_count_q <= press_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    // Bounce: drop back without a strobe.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: still held, no new strobe.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
`ifdef BTN_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    // Runs only while staying in PRESSED; entering PRESSED (from either
    // wait state) starts it from zero, every other state holds it clear.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (state_q == PRESSED && state_d == PRESSED) begin
            if (rep_q == REP_LAST) begin
                rep_fire = 1'b1;
            end else begin
                rep_d = rep_q + REP_ONE;
            end
        end
    end
`else
    assign rep_fire = 1'b0;

    wire unused_repeat_cfg = ^REPEAT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    assign strobe = accept | rep_fire;

    always_comb begin
        bit_valid_d   = strobe;
        bit_data_d    = bit_data_q;
        press_count_d = press_count_q;
        if (strobe) begin
            bit_data_d    = sw_s;
            press_count_d = press_count_q + 8'd1;
        end
        btn_level_d = (state_d == PRESSED) ||
                      (state_d == RELEASE_WAIT);
    end

    assign bus.bit_valid   = bit_valid_q;
    assign bus.bit_data    = bit_data_q;
    assign bus.btn_level   = btn_level_q;
    assign bus.press_count = press_count_q;

endmodule

// File: doc/button_bit_sampler.md
Name: button_bit_sampler

Overview:
- Front-end stage for the serial sequence detector.
- Turns a raw mechanical push-button plus a raw slide switch into a clean, single-cycle "bit entered" strobe with the switch value captured at that moment.
- Output pair bit_valid/bit_data drives the detector's edge/input pins directly, replacing its bare two-flop edge logic.
- Also supplies a debounced button level and a wrapping press counter for display or debug.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples required to accept a press or release (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 20: debounce counter width.
- REPEAT_CYCLES, 50000000: hold interval between auto-repeat strobes; used only with BTN_REPEAT_EN.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst_n, input, 1: synchronous active-low reset.
- button, input, 1: raw asynchronous push-button, bouncy, active-high.
- sw0, input, 1: raw asynchronous slide switch, the data bit.
- bit_valid, output, 1: one-cycle strobe per accepted press.
- bit_data, output, 1: sw0 value captured with the strobe; holds until the next strobe.
- btn_level, output, 1: debounced button level.
- press_count, output, 8: number of accepted strobes, wrapping.

Behaviour:
- Synchronizers: button and sw0 each pass through two flops (sync_btn, sync_sw). No logic reads raw inputs.
- Reset, when rst_n=0 at a posedge:
  - state=IDLE, cnt=0, sync flops=0.
  - bit_valid=0, bit_data=0, btn_level=0, press_count=0.
  - Reset has priority over everything, including mid-debounce and mid-press.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - sync_btn=1: go to PRESS_WAIT, cnt<=1.
  - Otherwise stay, cnt<=0.
- PRESS_WAIT:
  - sync_btn=0: go to IDLE, cnt<=0 (bounce rejected, no strobe).
  - sync_btn=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, cnt<=0, bit_valid<=1, bit_data<=sync_sw, press_count<=press_count+1.
  - Else cnt<=cnt+1.
- PRESSED:
  - sync_btn=0: go to RELEASE_WAIT, cnt<=1.
  - Else stay.
- RELEASE_WAIT:
  - sync_btn=1: go back to PRESSED, cnt<=0 (release bounce; no new strobe).
  - cnt==DEBOUNCE_CYCLES-1 with sync_btn=0: go to IDLE, cnt<=0.
  - Else cnt<=cnt+1.
- bit_valid: registered, high for exactly one cycle, deasserted the following cycle unconditionally.
- Latency: first posedge sampling button=1 is edge k. With button then held steady, bit_valid is high in the cycle after edge k+DEBOUNCE_CYCLES+1.
- btn_level=1 in PRESSED and RELEASE_WAIT, 0 otherwise; registered alongside the state.
- bit_data:
  - Captured from sync_sw in the same cycle the strobe is generated.
  - Later sw0 changes while held do not alter it.
  - Unchanged by a rejected bounce.
- press_count: 8-bit, 255+1 wraps to 0.
- Button held through reset: after rst_n rises, the sync flops refill, IDLE sees 1 and a full debounce runs. One strobe is produced, by design.
- Glitch shorter than DEBOUNCE_CYCLES in either direction never produces a strobe or a btn_level change.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - A repeat counter (width ceil(log2(REPEAT_CYCLES+1))) runs only in PRESSED; it is cleared on entry and in every other state.
  - At REPEAT_CYCLES-1 it clears and issues a strobe with the same update rules as a press (bit_valid=1, bit_data<=current sync_sw, press_count+1).
  - RELEASE_WAIT pauses and clears it.
- Undefined: no repeat counter exists; exactly one strobe per debounced press regardless of hold time.

Test Plan:
- Reset and clean press: DEBOUNCE_CYCLES=4, assert rst_n=0 for 3 cycles then release; check all outputs 0. sw0=1, button 0->1 at edge 10, held 20 cycles -> one bit_valid pulse in cycle after edge 15, bit_data=1, press_count=1, btn_level=1.
- Bounce rejection: DEBOUNCE_CYCLES=4, button toggles 1,0,1,1,0,1 on successive edges, then stays 0 -> no bit_valid, press_count=0, btn_level=0.
- Release bounce: hold pressed, release with 2-cycle glitches back to 1 -> no second strobe; btn_level drops only after 4 consecutive 0 samples.
- Data capture: sw0=0 at press, sw0 set to 1 two cycles after the strobe while still held -> bit_data stays 0. Next press with sw0=1 -> bit_data=1.
- Sequence and wrap: feed presses with bits 1,1,0,0 -> bit_data sequence 1,1,0,0 on four strobes. Then 252 more presses -> press_count wraps to 0.
- BTN_REPEAT_EN with REPEAT_CYCLES=8: hold 30 cycles after acceptance -> 1 press strobe + 3 repeat strobes spaced 8 cycles apart; rst_n=0 mid-hold -> no strobe during reset, all outputs 0.
